pc_gen_unit: RTL
================

# pc_gen_unit

Parametrised program-counter generation unit for the RV32I pipeline fetch stage. Holds the architectural fetch PC and steps it by 4, or by 2 when compressed support is enabled. Applies trap and branch/jump redirects with fixed priority, honours stall and fetch back-pressure, and supports halt/resume. It produces the PC for instruction memory and the link address (PC + step) for JAL/JALR write-back.

## Interface
Parameters:
- XLEN, 32, datapath width of PC and all address ports
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- C_EXT, 0, 1 enables 2-byte steps and 2-byte target alignment

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall_i  input  1  hazard stall from pipeline control; blocks sequential advance
- fetch_ready_i  input  1  instruction memory accepts pc_o this cycle
- compressed_i  input  1  current fetch is 16-bit; ignored when C_EXT=0
- redirect_valid_i  input  1  branch/jump taken, from EX
- redirect_pc_i  input  XLEN  branch/jump target
- trap_valid_i  input  1  trap/exception entry
- trap_vec_i  input  XLEN  trap handler address
- halt_i  input  1  request to stop fetching
- resume_i  input  1  leave HALT
- pc_o  output  XLEN  current fetch PC
- pc_valid_o  output  1  pc_o is a valid fetch request
- link_o  output  XLEN  pc_o + step, combinational
- misalign_o  output  1  one-cycle pulse: last redirect target was rejected as misaligned
- misalign_addr_o  output  XLEN  offending target, held until next misalign

## Operation
- step = 2 when C_EXT=1 and compressed_i=1, else 4.
- Target alignment rules:
  - C_EXT=0: target[1:0] must be 00.
  - C_EXT=1: target[0] must be 0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset. pc_valid_o=0. Next cycle goes to HALT if halt_i, else RUN.
  - RUN: pc_valid_o=1. halt_i (with no trap/redirect) goes to HALT, pc held.
  - HALT: pc_valid_o=0. resume_i goes to RUN. trap_valid_i loads trap_vec_i and goes to RUN. redirect_valid_i loads its target and stays in HALT.
- PC update priority, highest first:
  1. trap_valid_i: pc <= trap_vec_i. The trap vector is not alignment-checked.
  2. redirect_valid_i with aligned target: pc <= redirect_pc_i.
  3. redirect_valid_i with misaligned target: pc held; misalign_o=1 next cycle; misalign_addr_o <= target.
  4. halt_i in RUN: pc held.
  5. Advance when state=RUN, fetch_ready_i=1 and stall_i=0: pc <= pc + step.
  6. Otherwise pc held.
- Trap and redirect act regardless of stall_i and fetch_ready_i.
- Arithmetic is modulo 2^XLEN. Carry-out is discarded, so 0xFFFF_FFFC + 4 = 0x0000_0000.
- link_o uses the same step and wrap rule.

## Timing
- Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0, misalign_addr_o=0, state=BOOT.
- The first valid fetch appears on the second cycle after rst deasserts (one BOOT cycle).
- Redirect/trap latency is 1 cycle: the target is on pc_o in the cycle after the valid. No bubble is inserted; pc_valid_o stays 1 in RUN.
- Advance latency is 1 cycle after the accepted fetch (pc_valid_o & fetch_ready_i & !stall_i).
- misalign_o is high for exactly one cycle, the cycle after the offending redirect.
- Simultaneous events:
  - trap + redirect: trap wins; no misalign is reported.
  - redirect + halt_i in RUN: pc loads the target and state goes to HALT.
  - resume_i + halt_i in HALT: stay HALT.
- rst asserted mid-operation overrides everything in that cycle and returns all state to reset values.
- link_o is combinational from pc_o and compressed_i; it is the only combinational path.

## Structure
- The shared package (rv32i_pkg) holds:
  - the pc_state_e enum (BOOT, RUN, HALT);
  - the PC_STEP_WORD=4 and PC_STEP_HALF=2 constants;
  - the alignment-check function.
- One sub-module, pc_step_adder: parametrised XLEN adder, pc + {2 or 4}, wrap-around. It is instantiated twice: once for next-PC, once for link_o.
- The top level contains the FSM, priority mux, PC register and misalign registers.

## Test plan
- Reset/boot: RESET_VECTOR=0x100, rst high 3 cycles then low, fetch_ready_i=1 -> pc_valid_o=0 for 1 cycle, then pc_o = 0x100, 0x104, 0x108.
- Stall and back-pressure: in RUN at pc=0x200, stall_i=1 for 2 cycles then fetch_ready_i=0 for 1 cycle -> pc_o holds 0x200 for 3 cycles, then 0x204.
- Priority and redirect during stall: stall_i=1 with redirect 0x400 -> pc_o=0x400 next cycle. Trap 0x80 plus redirect 0x400 in the same cycle -> pc_o=0x80, misalign_o=0.
- Misalign: C_EXT=0, redirect 0x402 -> pc unchanged, misalign_o pulses 1 cycle, misalign_addr_o=0x402. C_EXT=1, redirect 0x402 -> accepted. compressed_i=1 at 0x402 -> next pc_o=0x404, link_o=0x404.
- Wrap: pc=0xFFFF_FFFC, advance -> pc_o=0x0000_0000; link_o at 0xFFFF_FFFC = 0x0.
- Halt/resume: halt_i at pc=0x300 -> pc_valid_o=0, pc holds 0x300. Redirect 0x500 in HALT -> pc_o=0x500, still HALT. resume_i -> pc_valid_o=1 at 0x500. Trap 0x80 while halted -> RUN at 0x80.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-stage definitions: PC FSM states, step sizes and the
// redirect target alignment rule.
package rv32i_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int PC_STEP_WORD = 4;
  localparam int PC_STEP_HALF = 2;

  // With compressed support only halfword alignment is required.
  function automatic logic target_aligned(input logic [1:0] low_bits, input bit c_ext);
    return c_ext ? ~low_bits[0] : (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch-side bundle of the PC generation unit: pipeline control in, fetch
// request, link address and misalign report out.
interface pc_gen_unit_if #(parameter int XLEN = 32) ();
  logic            stall_i;
  logic            fetch_ready_i;
  logic            compressed_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_vec_i;
  logic            halt_i;
  logic            resume_i;
  logic [XLEN-1:0] pc_o;
  logic            pc_valid_o;
  logic [XLEN-1:0] link_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  modport master (
    output stall_i, fetch_ready_i, compressed_i, redirect_valid_i, redirect_pc_i,
           trap_valid_i, trap_vec_i, halt_i, resume_i,
    input  pc_o, pc_valid_o, link_o, misalign_o, misalign_addr_o
  );

  modport slave (
    input  stall_i, fetch_ready_i, compressed_i, redirect_valid_i, redirect_pc_i,
           trap_valid_i, trap_vec_i, halt_i, resume_i,
    output pc_o, pc_valid_o, link_o, misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/pc_step_adder.sv
// Adds a 2- or 4-byte step to a PC; the carry-out is dropped so the
// address space wraps.
module pc_step_adder
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic            half_step,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] step;

  assign step = half_step ? XLEN'(PC_STEP_HALF) : XLEN'(PC_STEP_WORD);
  assign sum  = base + step;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN/HALT control, trap > redirect > halt > advance
// priority, misaligned-redirect reporting and the JAL/JALR link address.
module pc_gen_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_unit_if.slave    bus
);

  pc_state_e       state, state_next;
  logic [XLEN-1:0] pc, pc_next, seq_pc;
  logic            misalign, misalign_next;
  logic [XLEN-1:0] misalign_addr, misalign_addr_next;
  logic            half_step;
  logic            redirect_ok;

  assign half_step   = C_EXT && bus.compressed_i;
  assign redirect_ok = target_aligned(bus.redirect_pc_i[1:0], C_EXT);

  pc_step_adder #(.XLEN(XLEN)) u_next_adder (
    .base      (pc),
    .half_step (half_step),
    .sum       (seq_pc)
  );

  pc_step_adder #(.XLEN(XLEN)) u_link_adder (
    .base      (pc),
    .half_step (half_step),
    .sum       (bus.link_o)
  );

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    misalign_next      = 1'b0;
    misalign_addr_next = misalign_addr;

    if (bus.trap_valid_i) begin
      pc_next = bus.trap_vec_i;
    end else if (bus.redirect_valid_i) begin
      if (redirect_ok) begin
        pc_next = bus.redirect_pc_i;
      end else begin
        misalign_next      = 1'b1;
        misalign_addr_next = bus.redirect_pc_i;
      end
    end else if (state == RUN && !bus.halt_i && bus.fetch_ready_i && !bus.stall_i) begin
      pc_next = seq_pc;
    end

    // A trap always leaves the unit fetching; halt only wins over redirects.
    unique case (state)
      BOOT:    state_next = bus.halt_i ? HALT : RUN;
      RUN:     if (bus.halt_i && !bus.trap_valid_i) state_next = HALT;
      HALT:    if (bus.trap_valid_i || (bus.resume_i && !bus.halt_i)) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      misalign      <= misalign_next;
      misalign_addr <= misalign_addr_next;
    end
  end

  assign bus.pc_o            = pc;
  assign bus.pc_valid_o      = (state == RUN);
  assign bus.misalign_o      = misalign;
  assign bus.misalign_addr_o = misalign_addr;

endmodule
